// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M-style multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, with early completion for divide-by-zero and overflow.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_r;
    logic [CW-1:0]     cnt_r;
    logic [2:0]        op_r;
    logic [XLEN-1:0]   a_mag_r;
    logic [XLEN-1:0]   b_mag_r;
    logic              neg_r;
    logic [2*XLEN-1:0] acc_r;
    logic [XLEN-1:0]   result_r;

    logic              a_signed_s;
    logic              b_signed_s;
    logic              sa_s;
    logic              sb_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic              neg_s;
    logic              div_zero_s;
    logic              ovf_s;
    logic [XLEN-1:0]   early_res_s;

    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_shift_s;
    logic [XLEN+1:0]   div_diff_s;
    logic [2*XLEN-1:0] acc_next_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   final_res_s;

    // Request decode: operand magnitudes, result sign, and early-exit cases.
    always_comb begin
        a_signed_s  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_signed_s  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sa_s        = a_signed_s && a[XLEN-1];
        sb_s        = b_signed_s && b[XLEN-1];
        a_mag_s     = sa_s ? -a : a;
        b_mag_s     = sb_s ? -b : b;
        // Remainder follows the dividend; everything else is the XOR of signs.
        if (op == 3'b110) begin
            neg_s = sa_s;
        end else begin
            neg_s = sa_s ^ sb_s;
        end
        div_zero_s  = op[2] && (b == {XLEN{1'b0}});
        ovf_s       = op[2] && !op[0] && (a == MIN_NEG) && (b == {XLEN{1'b1}});
        early_res_s = {XLEN{1'b0}};
        if (div_zero_s) begin
            early_res_s = op[1] ? a : {XLEN{1'b1}};
        end else if (ovf_s) begin
            early_res_s = op[1] ? {XLEN{1'b0}} : a;
        end else begin
            early_res_s = {XLEN{1'b0}};
        end
    end

    // One iteration step plus sign-corrected final result selection.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]}
                    + (acc_r[0] ? {1'b0, a_mag_r} : {(XLEN+1){1'b0}});
        div_shift_s = acc_r[2*XLEN-1:XLEN-1];
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, b_mag_r};
        if (op_r[2]) begin
            if (!div_diff_s[XLEN+1]) begin
                acc_next_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end else begin
                acc_next_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
        prod_s = neg_r ? -acc_next_s : acc_next_s;
        quot_s = neg_r ? -acc_next_s[XLEN-1:0] : acc_next_s[XLEN-1:0];
        rem_s  = neg_r ? -acc_next_s[2*XLEN-1:XLEN] : acc_next_s[2*XLEN-1:XLEN];
        case (op_r)
            3'b000:                 final_res_s = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res_s = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res_s = quot_s;
            3'b110, 3'b111:         final_res_s = rem_s;
            default:                final_res_s = {XLEN{1'b0}};
        endcase
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CW{1'b0}};
            op_r     <= 3'b000;
            a_mag_r  <= {XLEN{1'b0}};
            b_mag_r  <= {XLEN{1'b0}};
            neg_r    <= 1'b0;
            acc_r    <= {(2*XLEN){1'b0}};
            result_r <= {XLEN{1'b0}};
        end else if (flush) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r    <= op;
                        a_mag_r <= a_mag_s;
                        b_mag_r <= b_mag_s;
                        neg_r   <= neg_s;
                        cnt_r   <= {CW{1'b0}};
                        // Divider iterates on the dividend, multiplier on rs2.
                        acc_r   <= op[2] ? {{XLEN{1'b0}}, a_mag_s} : {{XLEN{1'b0}}, b_mag_s};
                        if (div_zero_s || ovf_s) begin
                            result_r <= early_res_s;
                            state_r  <= ST_DONE;
                        end else begin
                            state_r  <= ST_BUSY;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        result_r <= final_res_s;
                        state_r  <= ST_DONE;
                    end else begin
                        state_r  <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    state_r <= out_ready ? ST_IDLE : ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r != ST_IDLE);
    assign result    = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=32): directed corner cases plus
// randomized operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    typedef struct {
        logic [XLEN-1:0] res;
        int              lat;
        int              acc_cyc;
    } exp_t;

    exp_t            sb_q[$];
    int              vectors = 0;
    int              miscompares = 0;
    int              cyc = 0;
    logic [XLEN-1:0] last_res = 32'h0;
    bit              rnd_bp = 1'b0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL global_timeout cycles=%0d required=<200000", cyc);
        $fatal(1);
    end

    // Reference model written directly from the RISC-V M-extension rules.
    function automatic logic [XLEN-1:0] ref_model(input logic [2:0] o, input logic [XLEN-1:0] x,
                                                  input logic [XLEN-1:0] y);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned ux = {32'd0, x};
        longint unsigned uy = {32'd0, y};
        longint          ps;
        longint unsigned pu;
        logic [XLEN-1:0] r;
        case (o)
            3'd0: begin pu = ux * uy; r = pu[31:0]; end
            3'd1: begin ps = sx * sy; r = ps[63:32]; end
            3'd2: begin ps = sx * longint'(uy); r = ps[63:32]; end
            3'd3: begin pu = ux * uy; r = pu[63:32]; end
            3'd4: begin
                if (y == 32'd0) r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
                else begin ps = sx / sy; r = ps[31:0]; end
            end
            3'd5: begin
                if (y == 32'd0) r = 32'hFFFF_FFFF;
                else begin pu = ux / uy; r = pu[31:0]; end
            end
            3'd6: begin
                if (y == 32'd0) r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
                else begin ps = sx % sy; r = ps[31:0]; end
            end
            default: begin
                if (y == 32'd0) r = x;
                else begin pu = ux % uy; r = pu[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [XLEN-1:0] x,
                                       input logic [XLEN-1:0] y);
        if (o[2] && y == 32'd0) return 1;
        if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [XLEN-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: compares the first cycle of each out_valid against the scoreboard head.
    initial begin
        bit   seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !seen) begin
                seen = 1'b1;
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_result actual=%h required=no_output", result);
                end else begin
                    e = sb_q.pop_front();
                    last_res = e.res;
                    if (result !== e.res || (cyc - e.acc_cyc) != e.lat) begin
                        miscompares++;
                        $display("FAIL result_check actual=%h@+%0d required=%h@+%0d",
                                 result, cyc - e.acc_cyc, e.res, e.lat);
                    end
                end
            end else if (!out_valid) begin
                seen = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                         input bit expect_out);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("issue_wait_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        if (expect_out) begin
            e.res = ref_model(o, x, y);
            e.lat = ref_latency(o, x, y);
            e.acc_cyc = cyc;
            sb_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        op = 3'($urandom);
        a = 32'($urandom);
        b = 32'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || !in_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;

        // Directed corner cases; result and latency are checked by the monitor.
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(3'd5, 32'd5, 32'd0, 1'b1);
        issue(3'd7, 32'd5, 32'd0, 1'b1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drain();

        // Backpressure: result held in DONE while out_ready is low.
        out_ready = 1'b0;
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_reached_done", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold_result", result, 32'hFFFF_FFFE);
        end
        // A request presented in the handshake cycle must not be taken.
        out_ready = 1'b1;
        in_valid = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_busy", {31'd0, busy}, 32'd0);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        drain();

        // Flush at BUSY cycle 10 discards the operation; result keeps last value.
        issue(3'd5, 32'd1000, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_result_hold", result, last_res);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("flush_no_valid", 32'(pulses), 32'd0);

        // Reset at BUSY cycle 10 also aborts and clears result.
        issue(3'd0, 32'd12345, 32'd678, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_abort_busy", {31'd0, busy}, 32'd0);
        check("rst_abort_result", result, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("rst_no_valid", 32'(pulses), 32'd0);

        // Flush beats in_valid in IDLE.
        flush = 1'b1; in_valid = 1'b1; op = 3'd5; a = 32'd9; b = 32'd0;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_vs_valid_busy", {31'd0, busy}, 32'd0);
        check("flush_vs_valid_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (5) @(negedge clk);

        // Randomized operations with random backpressure.
        rnd_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'b1);
        end
        drain();
        rnd_bp = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
